// File: rtl/cgra_cg_pkg.sv
// cgra_cg_pkg
// Shared types and default parameter values for the CGRA clock-gating
// controller (cgra_clock_gate_ctrl and its per-channel cell cgra_cg_chan).
//   cg_state_e  : per-channel gating FSM state
//   CG_*        : default parameter values used by the top and channel cell
package cgra_cg_pkg;

  typedef enum logic [1:0] {
    CG_RUN  = 2'd0,
    CG_COOL = 2'd1,
    CG_OFF  = 2'd2,
    CG_WAKE = 2'd3
  } cg_state_e;

  localparam int CG_N_CH     = 4;
  localparam int CG_CNT_W    = 8;
  localparam int CG_WAKE_CYC = 2;
  localparam int CG_STAT_W   = 32;

endpackage

// File: rtl/cgra_cg_chan.sv
// cgra_cg_chan
// One channel of the automatic clock-gating controller: idle-hysteresis
// FSM (RUN/COOL/OFF/WAKE), wake counter, optional OFF-cycle statistics
// counter and a latch-based glitch-free clock gate.
// Optional feature: CGRA_CG_STATS_EN adds the saturating OFF-cycle counter.
// Ports:
//   clk_i            ungated source clock
//   rst_i            synchronous active-high reset
//   test_en_i        force the gated clock running (FSM unaffected)
//   hyst_i           idle cycles tolerated before gating
//   idle_i           channel idle indication
//   force_on_i       channel must never be gated
//   wake_req_i       level wake request
//   wake_ack_o       clock running and stable (RUN or COOL), registered
//   gated_o          channel in OFF, registered
//   clk_o            gated clock
//   stat_gated_cnt_o cycles spent in OFF (stats build only)
module cgra_cg_chan
  import cgra_cg_pkg::*;
#(
  parameter int CNT_W    = CG_CNT_W,
  parameter int WAKE_CYC = CG_WAKE_CYC
`ifdef CGRA_CG_STATS_EN
  ,
  parameter int STAT_W   = CG_STAT_W
`endif
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             test_en_i,
  input  logic [CNT_W-1:0] hyst_i,
  input  logic             idle_i,
  input  logic             force_on_i,
  input  logic             wake_req_i,
  output logic             wake_ack_o,
  output logic             gated_o,
  output logic             clk_o
`ifdef CGRA_CG_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_gated_cnt_o
`endif
);

  localparam int WC_W = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;

  logic             idle_p0;
  logic             keep_p0;
  cg_state_e        state;
  cg_state_e        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [WC_W-1:0]  wcnt;
  logic [WC_W-1:0]  wcnt_nxt;
  logic             en;
  logic             en_lat;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wcnt_nxt  = wcnt;
    case (state)
      CG_RUN: begin
        if (idle_p0 && !keep_p0) begin
          state_nxt = CG_COOL;
          cnt_nxt   = hyst_i;
        end
      end
      CG_COOL: begin
        // keep wins over an expiring countdown
        if (!idle_p0 || keep_p0) begin
          state_nxt = CG_RUN;
        end else if (cnt == '0) begin
          state_nxt = CG_OFF;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      CG_OFF: begin
        // idle_i dropping alone does not wake; only keep does
        if (keep_p0) begin
          state_nxt = CG_WAKE;
          wcnt_nxt  = WC_W'(WAKE_CYC - 1);
        end
      end
      CG_WAKE: begin
        if (wcnt == '0) begin
          state_nxt = CG_RUN;
        end else begin
          wcnt_nxt = wcnt - 1'b1;
        end
      end
      default: state_nxt = CG_RUN;
    endcase
  end

  // stage p0: input sampling; FSM and flag outputs follow one edge later
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idle_p0    <= 1'b0;
      keep_p0    <= 1'b0;
      state      <= CG_RUN;
      cnt        <= '0;
      wcnt       <= '0;
      gated_o    <= 1'b0;
      wake_ack_o <= 1'b1;
    end else begin
      idle_p0    <= idle_i;
      keep_p0    <= wake_req_i | force_on_i;
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      wcnt       <= wcnt_nxt;
      gated_o    <= (state_nxt == CG_OFF);
      wake_ack_o <= (state_nxt == CG_RUN) || (state_nxt == CG_COOL);
    end
  end

`ifdef CGRA_CG_STATS_EN
  logic [STAT_W-1:0] stat;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat <= '0;
    end else if ((state == CG_OFF) && (stat != '1)) begin
      stat <= stat + 1'b1;
    end
  end

  assign stat_gated_cnt_o = stat;
`endif

  assign en = (state != CG_OFF) || test_en_i;

  // Enable only moves while clk_i is low, so a high pulse is never cut short
  always_latch begin
    if (!clk_i) begin
      en_lat <= en;
    end
  end

  assign clk_o = clk_i & en_lat;

endmodule

// File: rtl/cgra_clock_gate_ctrl.sv
// cgra_clock_gate_ctrl
// Multi-channel automatic clock-gating controller for the CGRA. Each
// channel gets an independent glitch-free gated clock that is shut off
// after hyst_i+2 idle cycles and restored through a wake handshake.
// Optional feature: CGRA_CG_STATS_EN adds per-channel OFF-cycle counters
// and the stat_gated_cnt_o port.
// Ports:
//   clk_i            ungated source clock
//   rst_i            synchronous active-high reset
//   test_en_i        force every clk_o running
//   hyst_i           shared idle hysteresis
//   idle_i           per-channel idle
//   force_on_i       per-channel never-gate
//   wake_req_i       per-channel wake request
//   wake_ack_o       per-channel clock running and stable
//   gated_o          per-channel OFF indication
//   clk_o            per-channel gated clocks
//   stat_gated_cnt_o per-channel OFF-cycle counters (stats build only)
module cgra_clock_gate_ctrl
  import cgra_cg_pkg::*;
#(
  parameter int N_CH     = CG_N_CH,
  parameter int CNT_W    = CG_CNT_W,
  parameter int WAKE_CYC = CG_WAKE_CYC
`ifdef CGRA_CG_STATS_EN
  ,
  parameter int STAT_W   = CG_STAT_W
`endif
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             test_en_i,
  input  logic [CNT_W-1:0] hyst_i,
  input  logic [N_CH-1:0]  idle_i,
  input  logic [N_CH-1:0]  force_on_i,
  input  logic [N_CH-1:0]  wake_req_i,
  output logic [N_CH-1:0]  wake_ack_o,
  output logic [N_CH-1:0]  gated_o,
  output logic [N_CH-1:0]  clk_o
`ifdef CGRA_CG_STATS_EN
  ,
  output logic [N_CH*STAT_W-1:0] stat_gated_cnt_o
`endif
);

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    cgra_cg_chan #(
      .CNT_W    (CNT_W),
      .WAKE_CYC (WAKE_CYC)
`ifdef CGRA_CG_STATS_EN
      ,
      .STAT_W   (STAT_W)
`endif
    ) u_chan (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .test_en_i  (test_en_i),
      .hyst_i     (hyst_i),
      .idle_i     (idle_i[i]),
      .force_on_i (force_on_i[i]),
      .wake_req_i (wake_req_i[i]),
      .wake_ack_o (wake_ack_o[i]),
      .gated_o    (gated_o[i]),
      .clk_o      (clk_o[i])
`ifdef CGRA_CG_STATS_EN
      ,
      .stat_gated_cnt_o (stat_gated_cnt_o[i*STAT_W +: STAT_W])
`endif
    );
  end

endmodule

// File: tb/tb_cgra_clock_gate_ctrl.sv
module tb_cgra_clock_gate_ctrl;

  localparam int N_CH     = 4;
  localparam int CNT_W    = 8;
  localparam int WAKE_CYC = 2;
`ifdef CGRA_CG_STATS_EN
  localparam int STAT_W   = 4;
`endif

  logic             clk;
  logic             rst;
  logic             test_en;
  logic [CNT_W-1:0] hyst;
  logic [N_CH-1:0]  idle;
  logic [N_CH-1:0]  force_on;
  logic [N_CH-1:0]  wake_req;
  logic [N_CH-1:0]  wake_ack;
  logic [N_CH-1:0]  gated;
  logic [N_CH-1:0]  gclk;
`ifdef CGRA_CG_STATS_EN
  logic [N_CH*STAT_W-1:0] stat;
`endif

  int total = 0;
  int bad   = 0;
  bit chk_glitch = 1'b0;
  int glitch_cnt = 0;

  cgra_clock_gate_ctrl #(
    .N_CH     (N_CH),
    .CNT_W    (CNT_W),
    .WAKE_CYC (WAKE_CYC)
`ifdef CGRA_CG_STATS_EN
    ,
    .STAT_W   (STAT_W)
`endif
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .test_en_i  (test_en),
    .hyst_i     (hyst),
    .idle_i     (idle),
    .force_on_i (force_on),
    .wake_req_i (wake_req),
    .wake_ack_o (wake_ack),
    .gated_o    (gated),
    .clk_o      (gclk)
`ifdef CGRA_CG_STATS_EN
    ,
    .stat_gated_cnt_o (stat)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // a gated-clock edge must coincide with the matching source edge
  always @(posedge gclk[0]) if (chk_glitch && clk !== 1'b1) glitch_cnt++;
  always @(negedge gclk[0]) if (chk_glitch && clk !== 1'b0) glitch_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; test_en = 1'b0; idle = '0; force_on = '0; wake_req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    total++; if (wake_ack !== 4'b1111) begin bad++; $display("FAIL reset_ack: got %b want 1111", wake_ack); end
    total++; if (gated !== 4'b0000) begin bad++; $display("FAIL reset_gated: got %b want 0000", gated); end
    total++; if (gclk !== 4'b1111) begin bad++; $display("FAIL reset_clk_hi: got %b want 1111", gclk); end
    #5;
    total++; if (gclk !== 4'b0000) begin bad++; $display("FAIL reset_clk_lo: got %b want 0000", gclk); end
`ifdef CGRA_CG_STATS_EN
    total++; if (stat !== '0) begin bad++; $display("FAIL reset_stat: got %h want 0", stat); end
`endif
    chk_glitch = 1'b1;
  endtask

  // hyst=3: idle sampled at t, OFF at t+5, first suppressed pulse at t+6
  task automatic test_basic_gating;
    do_reset();
    hyst = 8'd3;
    idle[0] = 1'b1;
    tick();                          // t
    tick(); tick(); tick(); tick();  // t+4
    total++; if (gated[0] !== 1'b0) begin bad++; $display("FAIL gate_early: got %b want 0", gated[0]); end
    tick();                          // t+5
    total++; if (gated !== 4'b0001) begin bad++; $display("FAIL gate_on: got %b want 0001", gated); end
    total++; if (gclk !== 4'b1111) begin bad++; $display("FAIL gate_last_pulse: got %b want 1111", gclk); end
    tick();                          // t+6
    total++; if (gclk !== 4'b1110) begin bad++; $display("FAIL gate_first_off: got %b want 1110", gclk); end
    tick(); tick();
    total++; if (gclk !== 4'b1110) begin bad++; $display("FAIL gate_flat: got %b want 1110", gclk); end
  endtask

  // continues from channel 0 in OFF
  task automatic test_wake;
    wake_req[0] = 1'b1;
    tick();                          // w
    wake_req[0] = 1'b0;
    total++; if (gated[0] !== 1'b1) begin bad++; $display("FAIL wake_still_off: got %b want 1", gated[0]); end
    tick();                          // w+1
    total++; if ({gated[0], wake_ack[0], gclk[0]} !== 3'b000) begin
      bad++; $display("FAIL wake_w1: got g/a/c=%b want 000", {gated[0], wake_ack[0], gclk[0]});
    end
    tick();                          // w+2
    total++; if ({wake_ack[0], gclk[0]} !== 2'b01) begin
      bad++; $display("FAIL wake_w2: got a/c=%b want 01", {wake_ack[0], gclk[0]});
    end
    tick();                          // w+3
    total++; if (wake_ack[0] !== 1'b1) begin bad++; $display("FAIL wake_ack: got %b want 1", wake_ack[0]); end
    idle[0] = 1'b0;
    total++; if (glitch_cnt !== 0) begin bad++; $display("FAIL wake_glitch: got %0d want 0", glitch_cnt); end
  endtask

  task automatic test_hyst_zero;
    do_reset();
    hyst = 8'd0;
    idle[1] = 1'b1;
    tick();                          // t
    tick();                          // t+1
    total++; if (gated[1] !== 1'b0) begin bad++; $display("FAIL h0_cool: got %b want 0", gated[1]); end
    tick();                          // t+2
    total++; if (gated[1] !== 1'b1) begin bad++; $display("FAIL h0_off: got %b want 1", gated[1]); end
  endtask

  // continues from channel 1 in OFF with idle[1] held
  task automatic test_overrides;
    int errs;
    test_en = 1'b1;
    tick();
    total++; if ({gated[1], gclk[1]} !== 2'b11) begin
      bad++; $display("FAIL test_en_hi: got g/c=%b want 11", {gated[1], gclk[1]});
    end
    #5;
    total++; if (gclk[1] !== 1'b0) begin bad++; $display("FAIL test_en_lo: got %b want 0", gclk[1]); end
    test_en = 1'b0;
    force_on[2] = 1'b1;
    idle[2] = 1'b1;
    errs = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (gated[2] !== 1'b0) errs++;
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL force_on: got %0d gated cycles want 0", errs); end
  endtask

  // keep arrives in the same cycle the countdown reaches zero
  task automatic test_keep_race;
    do_reset();
    hyst = 8'd3;
    idle[3] = 1'b1;
    tick();                          // t
    tick(); tick(); tick();          // t+3
    wake_req[3] = 1'b1;
    tick();                          // t+4, cnt==0
    tick();                          // t+5
    total++; if ({gated[3], wake_ack[3]} !== 2'b01) begin
      bad++; $display("FAIL race_keep: got g/a=%b want 01", {gated[3], wake_ack[3]});
    end
    wake_req[3] = 1'b0;
    idle[3] = 1'b0;
    tick(); tick();
    total++; if (gated[3] !== 1'b0) begin bad++; $display("FAIL race_after: got %b want 0", gated[3]); end
  endtask

  task automatic test_reset_mid_wake;
    do_reset();
    hyst = 8'd0;
    idle[1] = 1'b1;
    tick(); tick(); tick();          // OFF
    wake_req[1] = 1'b1;
    tick();                          // w
    wake_req[1] = 1'b0;
    tick();                          // w+1, WAKE
    total++; if ({gated[1], wake_ack[1]} !== 2'b00) begin
      bad++; $display("FAIL rw_inwake: got g/a=%b want 00", {gated[1], wake_ack[1]});
    end
    rst = 1'b1;
    tick();                          // w+2, reset edge
    rst = 1'b0;
    total++; if ({gated, wake_ack} !== 8'b0000_1111) begin
      bad++; $display("FAIL rw_run: got g/a=%b want 00001111", {gated, wake_ack});
    end
    tick();
    total++; if (gclk[1] !== 1'b1) begin bad++; $display("FAIL rw_clk: got %b want 1", gclk[1]); end
  endtask

`ifdef CGRA_CG_STATS_EN
  task automatic test_stats;
    do_reset();
    hyst = 8'd0;
    idle[0] = 1'b1;
    tick(); tick(); tick();          // t+2, OFF entered
    for (int i = 0; i < 5; i++) tick();
    total++; if (stat[3:0] !== 4'd5) begin bad++; $display("FAIL stat_count: got %0d want 5", stat[3:0]); end
    for (int i = 0; i < 20; i++) tick();
    total++; if (stat !== 16'h000F) begin bad++; $display("FAIL stat_sat: got %h want 000f", stat); end
  endtask
`endif

  initial begin
    rst = 1'b1; test_en = 1'b0; hyst = '0; idle = '0; force_on = '0; wake_req = '0;
    test_reset();
    test_basic_gating();
    test_wake();
    test_hyst_zero();
    test_overrides();
    test_keep_race();
    test_reset_mid_wake();
`ifdef CGRA_CG_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
